// File: rtl/decode_stage_if.sv
// Fetch-to-ID byte stream and ID-to-EX bundle handshake.
// The slave side is the decode stage; the master side is the surrounding pipeline.
interface decode_stage_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_byte;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_opcode;
  logic [1:0]        out_ra;
  logic [1:0]        out_rb;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [DATA_W-1:0] out_imm;
  logic              out_two_byte;

  modport master (
    output in_valid, in_byte, out_ready,
    input  in_ready, out_valid, out_opcode,
    input  out_ra, out_rb, out_a, out_b,
    input  out_imm, out_two_byte
  );

  modport slave (
    input  in_valid, in_byte, out_ready,
    output in_ready, out_valid, out_opcode,
    output out_ra, out_rb, out_a, out_b,
    output out_imm, out_two_byte
  );
endinterface

// File: rtl/decode_stage.sv
// ID stage: assembles 1/2-byte instructions, reads and bypasses
// operands, stalls on load-use and issues a registered ID/EX bundle.
module decode_stage #(
  parameter int DATA_W = 8,
  parameter int SP_IDX = 3
) (
  input  logic              clk,
  input  logic              rst,
  decode_stage_if.slave     bus,
  input  logic              flush,
  output logic [1:0]        raddr1,
  output logic [1:0]        raddr2,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic              wb_we,
  input  logic [1:0]        wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              wb_we2,
  input  logic [1:0]        wb_waddr2,
  input  logic [DATA_W-1:0] wb_wdata2,
  input  logic              ex_load,
  input  logic [1:0]        ex_rd
);
  localparam logic [1:0] S_OP    = 2'd0;
  localparam logic [1:0] S_IMM   = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] SP      = 2'(SP_IDX);

  logic [1:0]        state;
  logic [DATA_W-1:0] op_reg;
  logic [DATA_W-1:0] imm_reg;

  logic              v_q;
  logic [3:0]        opc_q;
  logic [1:0]        ra_q;
  logic [1:0]        rb_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] imm_q;
  logic              two_q;

  logic [3:0]        opcode;
  logic [1:0]        ra;
  logic [1:0]        rb;
  logic              stack_op;
  logic              two_byte;
  logic              in_two;
  logic              hazard;
  logic              can_issue;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

  assign opcode   = op_reg[7:4];
  assign ra       = op_reg[3:2];
  assign rb       = op_reg[1:0];
  assign two_byte = (op_reg[7:6] == 2'b11);
  assign in_two   = (bus.in_byte[7:6] == 2'b11);
  assign stack_op = opcode inside {4'h7, 4'h8, 4'hB, 4'hD};

  assign raddr1 = ra;
  assign raddr2 = stack_op ? SP : rb;

  // Port 2 wins, mirroring the register file's write priority.
  always_comb begin
    opnd_a = rdata1;
    if (wb_we2 && wb_waddr2 == raddr1)
      opnd_a = wb_wdata2;
    else if (wb_we && wb_waddr == raddr1)
      opnd_a = wb_wdata;
  end

  always_comb begin
    opnd_b = rdata2;
    if (wb_we2 && wb_waddr2 == raddr2)
      opnd_b = wb_wdata2;
    else if (wb_we && wb_waddr == raddr2)
      opnd_b = wb_wdata;
  end

  assign hazard = ex_load && (opcode != 4'h0) &&
                  (ex_rd == raddr1 || ex_rd == raddr2);
  assign can_issue = !hazard && (!v_q || bus.out_ready);

  assign bus.in_ready = (state != S_ISSUE) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_OP;
      op_reg  <= '0;
      imm_reg <= '0;
      v_q     <= 1'b0;
      opc_q   <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      two_q   <= 1'b0;
    end else if (flush) begin
      state   <= S_OP;
      op_reg  <= '0;
      imm_reg <= '0;
      v_q     <= 1'b0;
    end else begin
      if (v_q && bus.out_ready)
        v_q <= 1'b0;
      case (state)
        S_OP: begin
          if (bus.in_valid) begin
            op_reg  <= bus.in_byte;
            imm_reg <= '0;
            state   <= in_two ? S_IMM : S_ISSUE;
          end
        end
        S_IMM: begin
          if (bus.in_valid) begin
            imm_reg <= bus.in_byte;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (can_issue) begin
            v_q   <= 1'b1;
            opc_q <= opcode;
            ra_q  <= ra;
            rb_q  <= rb;
            a_q   <= opnd_a;
            b_q   <= opnd_b;
            imm_q <= imm_reg;
            two_q <= two_byte;
            state <= S_OP;
          end
        end
        default: state <= S_OP;
      endcase
    end
  end

  assign bus.out_valid    = v_q;
  assign bus.out_opcode   = opc_q;
  assign bus.out_ra       = ra_q;
  assign bus.out_rb       = rb_q;
  assign bus.out_a        = a_q;
  assign bus.out_b        = b_q;
  assign bus.out_imm      = imm_q;
  assign bus.out_two_byte = two_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with an instruction-level
// reference model compared against the DUT on every cycle.
module tb_decode_stage;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] raddr1, raddr2;
  logic [7:0] rdata1, rdata2;
  logic       wb_we = 0, wb_we2 = 0;
  logic [1:0] wb_waddr = 0, wb_waddr2 = 0;
  logic [7:0] wb_wdata = 0, wb_wdata2 = 0;
  logic       ex_load = 0;
  logic [1:0] ex_rd = 0;
  logic [7:0] rf [4];

  int tests = 0;
  int fails = 0;

  decode_stage_if #(.DATA_W(8)) bus ();

  decode_stage #(.DATA_W(8), .SP_IDX(3)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush(flush),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_we2(wb_we2), .wb_waddr2(wb_waddr2), .wb_wdata2(wb_wdata2),
    .ex_load(ex_load), .ex_rd(ex_rd)
  );

  always #5 clk = ~clk;

  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Reference model: counts bytes of the pending instruction,
  // issues it from the architectural rules once complete.
  int         m_cnt;
  logic [7:0] m_b0, m_b1;
  logic       m_vld;
  logic [3:0] m_op;
  logic [1:0] m_ra, m_rb;
  logic [7:0] m_a, m_b, m_imm;
  logic       m_two;

  function automatic int m_len(input logic [7:0] b);
    return (b[7:4] >= 4'hC) ? 2 : 1;
  endfunction

  function automatic bit m_complete();
    return m_cnt != 0 && m_cnt == m_len(m_b0);
  endfunction

  function automatic logic [1:0] m_r2();
    logic [3:0] op;
    op = m_b0[7:4];
    if (op == 4'h7 || op == 4'h8 || op == 4'hB || op == 4'hD)
      return 2'd3;
    return m_b0[1:0];
  endfunction

  function automatic logic [7:0] m_byp(input logic [1:0] r);
    if (wb_we2 && wb_waddr2 == r) return wb_wdata2;
    if (wb_we && wb_waddr == r) return wb_wdata;
    return rf[r];
  endfunction

  function automatic bit m_can_issue();
    bit haz;
    haz = ex_load && m_b0[7:4] != 4'h0 &&
          (ex_rd == m_b0[3:2] || ex_rd == m_r2());
    return !haz && (!m_vld || bus.out_ready);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0; m_b0 <= 0; m_b1 <= 0; m_vld <= 0;
      m_op <= 0; m_ra <= 0; m_rb <= 0;
      m_a <= 0; m_b <= 0; m_imm <= 0; m_two <= 0;
    end else if (flush) begin
      m_vld <= 0;
      m_cnt <= 0;
    end else begin
      if (m_vld && bus.out_ready) m_vld <= 0;
      if (m_complete()) begin
        if (m_can_issue()) begin
          m_vld <= 1;
          m_op  <= m_b0[7:4];
          m_ra  <= m_b0[3:2];
          m_rb  <= m_b0[1:0];
          m_a   <= m_byp(m_b0[3:2]);
          m_b   <= m_byp(m_r2());
          m_two <= (m_len(m_b0) == 2);
          m_imm <= (m_len(m_b0) == 2) ? m_b1 : 8'h00;
          m_cnt <= 0;
        end
      end else if (bus.in_valid) begin
        if (m_cnt == 0) m_b0 <= bus.in_byte;
        else m_b1 <= bus.in_byte;
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_in_ready", bus.in_ready, !m_complete() && !flush);
      chk("m_out_valid", bus.out_valid, m_vld);
      if (m_vld) begin
        chk("m_opcode", bus.out_opcode, m_op);
        chk("m_ra", bus.out_ra, m_ra);
        chk("m_rb", bus.out_rb, m_rb);
        chk("m_a", bus.out_a, m_a);
        chk("m_b", bus.out_b, m_b);
        chk("m_imm", bus.out_imm, m_imm);
        chk("m_two", bus.out_two_byte, m_two);
      end
      if (m_complete()) begin
        chk("m_raddr1", raddr1, m_b0[3:2]);
        chk("m_raddr2", raddr2, m_r2());
      end
    end
  end

  logic [3:0] xq[$];
  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready)
      xq.push_back(bus.out_opcode);

  task automatic send(input logic [7:0] b);
    bit r;
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    bus.in_valid = 1; bus.in_byte = b;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); r = bus.in_ready;
      @(posedge clk); #1;
      if (r) begin ok = 1; break; end
    end
    bus.in_valid = 0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL send_timeout: byte %0h not accepted", b);
    end
  endtask

  task automatic wait_valid(input string n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin ok = 1; break; end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: out_valid got 0 expected 1", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rf[0] = 8'h00; rf[1] = 8'h05; rf[2] = 8'h09; rf[3] = 8'h80;
    bus.in_valid = 0; bus.in_byte = 0; bus.out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_raddr1", raddr1, 0);
    chk("rst_raddr2", raddr2, 0);
    chk("rst_imm", bus.out_imm, 0);

    // 1-byte op
    send(8'h16);
    wait_valid("op16_valid");
    chk("op16_opcode", bus.out_opcode, 4'h1);
    chk("op16_a", bus.out_a, 8'h05);
    chk("op16_b", bus.out_b, 8'h09);
    chk("op16_imm", bus.out_imm, 0);
    chk("op16_two", bus.out_two_byte, 0);

    // 2-byte with idle gap
    send(8'hC4);
    repeat (3) begin
      @(negedge clk);
      chk("imm_gap_ready", bus.in_ready, 1);
      chk("imm_gap_valid", bus.out_valid, 0);
    end
    send(8'h3A);
    wait_valid("c4_valid");
    chk("c4_opcode", bus.out_opcode, 4'hC);
    chk("c4_imm", bus.out_imm, 8'h3A);
    chk("c4_two", bus.out_two_byte, 1);
    chk("c4_ra", bus.out_ra, 1);

    // stack op with both snoop ports
    wb_we = 1; wb_waddr = 1; wb_wdata = 8'h11;
    wb_we2 = 1; wb_waddr2 = 3; wb_wdata2 = 8'hFE;
    send(8'h74);
    chk("push_raddr2", raddr2, 3);
    wait_valid("push_valid");
    chk("push_a", bus.out_a, 8'h11);
    chk("push_b", bus.out_b, 8'hFE);
    wb_waddr2 = 1; wb_wdata2 = 8'h22;
    send(8'h74);
    wait_valid("push2_valid");
    chk("push2_a_port2", bus.out_a, 8'h22);
    chk("push2_b_rf", bus.out_b, 8'h80);
    @(posedge clk); #1;
    wb_we = 0; wb_we2 = 0;

    // load-use
    ex_load = 1; ex_rd = 2;
    send(8'h12);
    repeat (4) begin
      @(negedge clk);
      chk("lu_stall_valid", bus.out_valid, 0);
    end
    @(posedge clk); #1;
    ex_load = 0;
    @(posedge clk);
    @(negedge clk);
    chk("lu_issue_valid", bus.out_valid, 1);
    chk("lu_opcode", bus.out_opcode, 4'h1);
    chk("lu_b", bus.out_b, 8'h09);

    // backpressure
    @(posedge clk); #1;
    xq.delete();
    bus.out_ready = 0;
    send(8'h16);
    send(8'h25);
    repeat (4) begin
      @(negedge clk);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_opcode", bus.out_opcode, 4'h1);
      chk("bp_a", bus.out_a, 8'h05);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_xfer_count", xq.size(), 2);
    if (xq.size() == 2) begin
      chk("bp_first", xq[0], 4'h1);
      chk("bp_second", xq[1], 4'h2);
    end

    // flush in S_IMM
    xq.delete();
    send(8'hC4);
    flush = 1;
    @(negedge clk);
    chk("flush_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    flush = 0;
    send(8'h16);
    wait_valid("flush_valid");
    chk("flush_opcode", bus.out_opcode, 4'h1);
    chk("flush_two", bus.out_two_byte, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("flush_xfer_count", xq.size(), 1);

    // async reset while stalled in issue
    bus.out_ready = 0;
    send(8'h16);
    send(8'h25);
    #3 rst = 1;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_opcode", bus.out_opcode, 0);
    @(posedge clk); #1;
    rst = 0;
    bus.out_ready = 1;
    xq.delete();
    send(8'h30);
    wait_valid("arst_post_valid");
    chk("arst_post_opcode", bus.out_opcode, 4'h3);
    repeat (3) @(posedge clk);
    #1;
    chk("arst_xfer_count", xq.size(), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
